// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling feeding a circular byte FIFO.
// The receiver only raises a one-cycle push; the FIFO decides whether it fits.
module uart_rx_fifo #(
    parameter int CLKS_PER_TICK = 27,
    parameter int DEPTH         = 16,
    parameter int CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srx_pad_i,
    input  logic             rf_pop,
    output logic [7:0]       rdr,
    output logic [CNT_W-1:0] rf_counter,
    output logic             overrun,
    output logic             framing_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DIV_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_TICK - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [1:0]       settle_q;
    logic             armed_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tickCnt_q, tickCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             errWait_q, errWait_d;
    logic             tick, fallEdge, push, ferr_d;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             overrun_q, ferr_q;
    logic             doPop, doPush;

    assign tick     = (div_q == DIV_LAST);
    assign fallEdge = armed_q & prev_q & ~sync2_q;

    // armed_q keeps the synchronizer's reset value from posing as a start edge
    // when the line happens to be low at reset release (e.g. mid-frame).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= srx_pad_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            tickCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            errWait_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tickCnt_q <= tickCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            errWait_q <= errWait_d;
        end
    end

    // tickCnt_q wraps at 16, so "== 15" marks exactly one bit period between samples.
    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        tickCnt_d = tick ? tickCnt_q + 4'd1 : tickCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        errWait_d = errWait_q;
        push      = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fallEdge) begin
                    state_d   = START;
                    div_d     = '0;
                    tickCnt_d = '0;
                end
            end
            START: begin
                if (tick && tickCnt_q == 4'd7) begin
                    tickCnt_d = '0;
                    bitIdx_d  = '0;
                    state_d   = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tickCnt_q == 4'd15) begin
                    shift_d  = {sync2_q, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (errWait_q) begin
                    if (sync2_q) begin
                        errWait_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else if (tick && tickCnt_q == 4'd15) begin
                    if (sync2_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d    = 1'b1;
                        errWait_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign doPop  = rf_pop && (cnt_q != '0);
    assign doPush = push && ((cnt_q != CNT_FULL) || doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= shift_q;
                wrPtr_q        <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            overrun_q <= push && !doPush;
            ferr_q    <= ferr_d;
        end
    end

    assign rdr         = mem_q[rdPtr_q];
    assign rf_counter  = cnt_q;
    assign overrun     = overrun_q;
    assign framing_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner-case
// sequences, and randomized frames/pops compared against a queue model.
module tb_uart_rx_fifo;

    localparam int TICK  = 4;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;
    localparam int BIT   = 16 * TICK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             srxPad;
    logic             rfPop;
    logic [7:0]       rdr;
    logic [CNT_W-1:0] rfCounter;
    logic             overrun;
    logic             framingErr;

    int checks   = 0;
    int failures = 0;
    int ovCount  = 0;
    int feCount  = 0;
    int expOv    = 0;
    int expFe    = 0;
    int cyc      = 0;
    logic [7:0] model[$];

    typedef struct {
        bit         send;
        logic [7:0] data;
        bit         stopOk;
        int         pops;
        int         expCount;
        logic [7:0] expHead;
        int         expFeInc;
    } vec_t;

    vec_t vecs[7];

    uart_rx_fifo #(
        .CLKS_PER_TICK(TICK),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .srx_pad_i(srxPad),
        .rf_pop(rfPop),
        .rdr(rdr),
        .rf_counter(rfCounter),
        .overrun(overrun),
        .framing_err(framingErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun)    ovCount++;
            if (framingErr) feCount++;
        end
    end

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int idleBits);
        srxPad = 1'b0;
        waitCycles(BIT);
        for (int i = 0; i < 8; i++) begin
            srxPad = data[i];
            waitCycles(BIT);
        end
        srxPad = stopBit;
        waitCycles(BIT);
        srxPad = 1'b1;
        waitCycles(BIT * idleBits);
    endtask

    task automatic popOnce();
        rfPop = 1'b1;
        waitCycles(1);
        rfPop = 1'b0;
        waitCycles(1);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.send) sendFrame(v.data, v.stopOk, 1);
        for (int p = 0; p < v.pops; p++) popOnce();
        expFe += v.expFeInc;
        checkOutput("vec_count", rfCounter, v.expCount);
        if (v.expCount > 0) checkOutput("vec_head", rdr, v.expHead);
        checkOutput("vec_framing_pulses", feCount, expFe);
        checkOutput("vec_overrun_pulses", ovCount, expOv);
    endtask

    // Push must land one clock after the stop sample, i.e. near mid stop bit.
    task automatic measurePushLatency(input logic [7:0] data);
        int startCyc;
        int incCyc;
        int lat;
        int midStop;
        midStop  = 9 * BIT + BIT / 2;
        startCyc = cyc;
        incCyc   = -1;
        fork
            sendFrame(data, 1'b1, 1);
            begin
                for (int n = 0; n < 12 * BIT; n++) begin
                    @(negedge clk);
                    if (rfCounter != 0) begin
                        incCyc = cyc;
                        break;
                    end
                end
            end
        join
        lat = (incCyc < 0) ? -1 : incCyc - startCyc;
        checks++;
        if (lat < midStop || lat > midStop + 8) begin
            failures++;
            $display("[TB] FAIL push_latency: got %0d clks after start edge, expected %0d..%0d",
                     lat, midStop, midStop + 8);
        end
    endtask

    task automatic randomFrame(input int pops);
        logic [7:0] d;
        logic       ok;
        d  = 8'($urandom);
        ok = ($urandom_range(0, 9) != 0);
        fork
            sendFrame(d, ok, 1);
            begin
                waitCycles(2 * BIT);
                for (int p = 0; p < pops; p++) popOnce();
            end
        join
        for (int p = 0; p < pops; p++) begin
            if (model.size() > 0) void'(model.pop_front());
        end
        if (!ok)                        expFe++;
        else if (model.size() < DEPTH)  model.push_back(d);
        else                            expOv++;
        checkOutput("rand_count", rfCounter, model.size());
        if (model.size() > 0) checkOutput("rand_head", rdr, model[0]);
        checkOutput("rand_overrun_pulses", ovCount, expOv);
        checkOutput("rand_framing_pulses", feCount, expFe);
    endtask

    initial begin
        logic [7:0] burst[8];
        logic [7:0] fill[17];

        vecs[0] = '{1'b1, 8'h90, 1'b1, 0, 2, 8'hEB, 0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1, 1, 8'h90, 0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1, 0, 8'h00, 0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1, 0, 8'h00, 0};
        vecs[4] = '{1'b1, 8'h55, 1'b0, 0, 0, 8'h00, 1};
        vecs[5] = '{1'b1, 8'hAA, 1'b1, 0, 1, 8'hAA, 0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1, 0, 8'h00, 0};
        burst   = '{8'hEB, 8'h90, 8'h01, 8'hAB, 8'h0A, 8'h4A, 8'h09, 8'hD7};
        for (int i = 0; i < 17; i++) fill[i] = 8'(i * 37 + 5);

        rst_n  = 1'b0;
        srxPad = 1'b1;
        rfPop  = 1'b0;
        waitCycles(5);
        checkOutput("reset_rdr", rdr, 8'h00);
        checkOutput("reset_count", rfCounter, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_framing", framingErr, 0);
        rst_n = 1'b1;
        waitCycles(5);

        measurePushLatency(8'hEB);
        checkOutput("first_count", rfCounter, 1);
        checkOutput("first_head", rdr, 8'hEB);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        srxPad = 1'b0;
        waitCycles(4 * TICK);
        srxPad = 1'b1;
        waitCycles(3 * BIT);
        checkOutput("glitch_count", rfCounter, 0);
        checkOutput("glitch_framing_pulses", feCount, expFe);
        popOnce();
        checkOutput("glitch_pop_empty_count", rfCounter, 0);

        for (int i = 0; i < 8; i++) sendFrame(burst[i], 1'b1, (i == 7) ? 1 : 0);
        checkOutput("burst_count", rfCounter, 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput("burst_head", rdr, burst[i]);
            popOnce();
        end
        checkOutput("burst_drained", rfCounter, 0);

        for (int i = 0; i < 16; i++) sendFrame(fill[i], 1'b1, (i == 15) ? 1 : 0);
        checkOutput("full_count", rfCounter, DEPTH);
        checkOutput("full_no_overrun_yet", ovCount, expOv);
        sendFrame(fill[16], 1'b1, 1);
        expOv++;
        checkOutput("overrun_once", ovCount, expOv);
        checkOutput("overrun_count", rfCounter, DEPTH);
        checkOutput("overrun_head", rdr, fill[0]);
        for (int i = 0; i < 16; i++) begin
            checkOutput("full_drain_head", rdr, fill[i]);
            popOnce();
        end
        checkOutput("full_drained", rfCounter, 0);

        sendFrame(8'h11, 1'b1, 1);
        srxPad = 1'b0;
        waitCycles(BIT);
        for (int i = 0; i < 3; i++) begin
            srxPad = 1'b0;
            waitCycles(BIT);
        end
        srxPad = 1'b1;
        waitCycles(BIT / 2);
        rst_n = 1'b0;
        waitCycles(10);
        rst_n = 1'b1;
        checkOutput("midreset_count", rfCounter, 0);
        checkOutput("midreset_rdr", rdr, 8'h00);
        waitCycles(BIT / 2 - 10);
        for (int i = 4; i < 8; i++) waitCycles(BIT);
        waitCycles(2 * BIT);
        checkOutput("midreset_partial_dropped", rfCounter, 0);
        sendFrame(8'h3C, 1'b1, 1);
        checkOutput("midreset_next_count", rfCounter, 1);
        checkOutput("midreset_next_head", rdr, 8'h3C);

        model.push_back(8'h3C);
        for (int i = 0; i < 32; i++) randomFrame((i < 18) ? 0 : $urandom_range(0, 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
